// File: rtl/clock_disp_pkg.sv
// Shared definitions for the clock/display block: seven-segment patterns
// (active-low {g,f,e,d,c,b,a}) and the scan-index type.
package clock_disp_pkg;

    typedef logic [1:0] scan_idx_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/clock_disp_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal codes (10..15) show a blank digit.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup for one digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_disp.sv
// Clock divider and four-digit multiplexed seven-segment driver.
// Produces 1 Hz / 2 Hz enable pulses from a shared counter, a refresh strobe
// that advances the digit scan, and an optional blink square wave.
// Build option: define CLOCK_DISP_BLINK_EN to include the blink divider;
// otherwise CLK_BLINK is held at 0.
module clock_disp
    import clock_disp_pkg::*;
#(
    parameter int REF_HZ   = 100_000_000,
    parameter int FAST_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic       CLK_1HZ,
    output logic       CLK_2HZ,
    output logic       CLK_FAST,
    output logic       CLK_BLINK,
    output logic [6:0] dispDigit,
    output logic [3:0] selector
);

    localparam int D1 = REF_HZ;
    localparam int D2 = REF_HZ / 2;
    localparam int DF = REF_HZ / FAST_HZ;
    localparam int W1 = $clog2(D1);
    localparam int WF = $clog2(DF);

    localparam logic [W1-1:0] D1_LAST = W1'(D1 - 1);
    localparam logic [W1-1:0] D2_LAST = W1'(D2 - 1);
    localparam logic [WF-1:0] DF_LAST = WF'(DF - 1);

    logic [W1-1:0] slow_cnt_reg;
    logic          clk_1hz_reg;
    logic          clk_2hz_reg;
    logic [WF-1:0] fast_cnt_reg;
    logic          clk_fast_reg;
    scan_idx_t     scan_idx_reg;
    scan_idx_t     scan_idx_next;
    logic [3:0]    digit_sel;

    // Shared 1 Hz / 2 Hz divider: the 1 Hz terminal count is also a 2 Hz tick
    always_ff @(posedge clk) begin
        if (RESET) begin
            slow_cnt_reg <= '0;
            clk_1hz_reg  <= 1'b0;
            clk_2hz_reg  <= 1'b0;
        end else begin
            if (slow_cnt_reg == D1_LAST)
                slow_cnt_reg <= '0;
            else
                slow_cnt_reg <= slow_cnt_reg + W1'(1);
            clk_1hz_reg <= (slow_cnt_reg == D1_LAST);
            clk_2hz_reg <= (slow_cnt_reg == D2_LAST) || (slow_cnt_reg == D1_LAST);
        end
    end

    // Refresh strobe divider
    always_ff @(posedge clk) begin
        if (RESET) begin
            fast_cnt_reg <= '0;
            clk_fast_reg <= 1'b0;
        end else begin
            if (fast_cnt_reg == DF_LAST)
                fast_cnt_reg <= '0;
            else
                fast_cnt_reg <= fast_cnt_reg + WF'(1);
            clk_fast_reg <= (fast_cnt_reg == DF_LAST);
        end
    end

`ifdef CLOCK_DISP_BLINK_EN
    localparam int DB = REF_HZ / (2 * BLINK_HZ);
    localparam int WB = $clog2(DB);
    localparam logic [WB-1:0] DB_LAST = WB'(DB - 1);

    logic [WB-1:0] blink_cnt_reg;
    logic          blink_reg;

    // Blink square wave: toggle on each terminal count of the half-period
    always_ff @(posedge clk) begin
        if (RESET) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else if (blink_cnt_reg == DB_LAST) begin
            blink_cnt_reg <= '0;
            blink_reg     <= ~blink_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + WB'(1);
        end
    end

    assign CLK_BLINK = blink_reg;
`else
    assign CLK_BLINK = 1'b0;
`endif

    // Scan index advances once per refresh strobe, wrapping naturally at 3
    always_comb begin
        scan_idx_next = scan_idx_reg;
        if (clk_fast_reg)
            scan_idx_next = scan_idx_reg + 2'd1;
    end

    // Scan index register
    always_ff @(posedge clk) begin
        if (RESET)
            scan_idx_reg <= '0;
        else
            scan_idx_reg <= scan_idx_next;
    end

    // Active-low one-hot anode select, one bit per digit
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sel
            assign selector[gi] = (scan_idx_reg != 2'(gi));
        end
    endgenerate

    // Route the selected digit to the decoder without registering it
    always_comb begin
        digit_sel = d0;
        case (scan_idx_reg)
            2'd0: digit_sel = d0;
            2'd1: digit_sel = d1;
            2'd2: digit_sel = d2;
            2'd3: digit_sel = d3;
            default: digit_sel = d0;
        endcase
    end

    seg7_decode u_decode (
        .bcd (digit_sel),
        .seg (dispDigit)
    );

    assign CLK_1HZ  = clk_1hz_reg;
    assign CLK_2HZ  = clk_2hz_reg;
    assign CLK_FAST = clk_fast_reg;

endmodule

// File: tb/tb_clock_disp.sv
// Self-checking bench for clock_disp with REF_HZ=1000, FAST_HZ=100, BLINK_HZ=2.
// Expected outputs come from an edge-count model and are queued per clock.
module tb_clock_disp;

    localparam int REF_HZ   = 1000;
    localparam int FAST_HZ  = 100;
    localparam int BLINK_HZ = 2;
    localparam int P1 = 1000;   // edges per CLK_1HZ pulse
    localparam int P2 = 500;    // edges per CLK_2HZ pulse
    localparam int PF = 10;     // edges per CLK_FAST pulse
    localparam int PB = 250;    // edges per CLK_BLINK toggle

    logic       clk;
    logic       RESET;
    logic [3:0] d0, d1, d2, d3;
    logic       CLK_1HZ, CLK_2HZ, CLK_FAST, CLK_BLINK;
    logic [6:0] dispDigit;
    logic [3:0] selector;

    clock_disp #(
        .REF_HZ   (REF_HZ),
        .FAST_HZ  (FAST_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .CLK_1HZ   (CLK_1HZ),
        .CLK_2HZ   (CLK_2HZ),
        .CLK_FAST  (CLK_FAST),
        .CLK_BLINK (CLK_BLINK),
        .dispDigit (dispDigit),
        .selector  (selector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       c1;
        logic       c2;
        logic       cf;
        logic       bl;
        logic [3:0] sel;
        logic [6:0] seg;
    } exp_t;

    typedef struct packed {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [6:0] seg;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n = 0;          // non-reset edges since last reset
    logic [3:0] dig [4];

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t model(input int edges);
        exp_t e;
        int   idx;
        idx   = (edges == 0) ? 0 : ((edges - 1) / PF) % 4;
        e.c1  = (edges > 0) && (edges % P1 == 0);
        e.c2  = (edges > 0) && (edges % P2 == 0);
        e.cf  = (edges > 0) && (edges % PF == 0);
`ifdef CLOCK_DISP_BLINK_EN
        e.bl  = ((edges / PB) % 2) == 1;
`else
        e.bl  = 1'b0;
`endif
        e.sel = 4'b1111;
        e.sel[idx] = 1'b0;
        e.seg = seg_ref(dig[idx]);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, req);
        end
    endtask

    // One clock: drive RESET, queue the model's prediction, compare after the edge
    task automatic step(input logic rst);
        exp_t e;
        exp_t got;
        RESET = rst;
        if (rst) n = 0;
        else     n++;
        sb.push_back(model(n));
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard empty at edge %0d", n);
        end else begin
            e = sb.pop_front();
            got = '{CLK_1HZ, CLK_2HZ, CLK_FAST, CLK_BLINK, selector, dispDigit};
            chk("CLK_1HZ",   int'(CLK_1HZ),   int'(e.c1));
            chk("CLK_2HZ",   int'(CLK_2HZ),   int'(e.c2));
            chk("CLK_FAST",  int'(CLK_FAST),  int'(e.cf));
            chk("CLK_BLINK", int'(CLK_BLINK), int'(e.bl));
            chk("selector",  int'(selector),  int'(e.sel));
            chk("dispDigit", int'(dispDigit), int'(e.seg));
            if (rst || e.c2 || e.bl != got.bl)
                $display("edge %0d rst=%0b: 1hz=%0b 2hz=%0b fast=%0b blink=%0b sel=%b seg=%h",
                         n, rst, got.c1, got.c2, got.cf, got.bl, got.sel, got.seg);
        end
    endtask

    vec_t vecs [18];

    initial begin
        dig[0] = 4'd1; dig[1] = 4'd2; dig[2] = 4'd3; dig[3] = 4'd4;
        RESET = 1'b1;
        d0 = dig[0]; d1 = dig[1]; d2 = dig[2]; d3 = dig[3];

        // Decode table: d0 is selected while in reset; d1 changes must not show
        for (int i = 0; i < 16; i++)
            vecs[i] = '{4'(i), 4'(15 - i), seg_ref(4'(i))};
        vecs[16] = '{4'd12, 4'd8, 7'h7F};
        vecs[17] = '{4'd8,  4'd12, 7'h00};

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step(1'b1);

        // Combinational decode, checked without any clock edge in between
        for (int i = 0; i < 18; i++) begin
            d0 = vecs[i].d0;
            d1 = vecs[i].d1;
            #1;
            chk("decode",     int'(dispDigit), int'(vecs[i].seg));
            chk("sel_reset",  int'(selector),  int'(4'b1110));
            $display("vec %0d: d0=%0d d1=%0d seg=%h", i, vecs[i].d0, vecs[i].d1, dispDigit);
            @(negedge clk);
        end
        d0 = dig[0]; d1 = dig[1];

        // Divider, refresh/scan and blink run
        for (int i = 0; i < 2000; i++) step(1'b0);

        // Fresh start, then a one-cycle reset at cycle 740
        step(1'b1);
        for (int i = 0; i < 739; i++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 600; i++) step(1'b0);

        // Digit change while d0 is selected again (index back at 0 right after reset)
        step(1'b1);
        d0 = 4'd12; #1;
        chk("blank_run", int'(dispDigit), int'(7'h7F));
        d0 = 4'd8;  #1;
        chk("eight_run", int'(dispDigit), int'(7'h00));
        $display("run decode: d0=%0d seg=%h", d0, dispDigit);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clock_disp.md
CLOCK_DISP -- requirements
Module: clock_disp

Interface
REQ-001 The block SHALL have parameter REF_HZ, default 100_000_000, giving the clk frequency in Hz.
REQ-002 The block SHALL have parameter FAST_HZ, default 1000, giving the display-refresh strobe rate in Hz.
REQ-003 The block SHALL have parameter BLINK_HZ, default 2, giving the blink square-wave frequency in Hz.
REQ-004 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 The block SHALL have port RESET, input, 1 bit, synchronous, active-high reset.
REQ-006 The block SHALL have ports d0, d1, d2, d3, input, 4 bits each, BCD digit values; d0 is the rightmost digit.
REQ-007 The block SHALL have ports CLK_1HZ and CLK_2HZ, output, 1 bit each, single-cycle enable pulses.
REQ-008 The block SHALL have port CLK_FAST, output, 1 bit, single-cycle refresh pulse.
REQ-009 The block SHALL have port CLK_BLINK, output, 1 bit, 50% duty square wave.
REQ-010 The block SHALL have port dispDigit, output, 7 bits, active-low segments {g,f,e,d,c,b,a}.
REQ-011 The block SHALL have port selector, output, 4 bits, active-low one-hot anode select; bit i selects digit di.

Function
REQ-012 Divisor rules SHALL be: D1 = REF_HZ, D2 = REF_HZ/2, DF = REF_HZ/FAST_HZ, DB = REF_HZ/(2*BLINK_HZ); all divisors are integers of at least 2, and counter widths are derived with $clog2.
REQ-013 Each pulse output SHALL come from a register and be high for exactly one clk cycle, following the k*Dx-th non-reset rising edge after reset release (k = 1, 2, ...).
REQ-014 CLK_1HZ and CLK_2HZ SHALL share one counter, so every CLK_1HZ pulse coincides with a CLK_2HZ pulse.
REQ-015 CLK_BLINK SHALL toggle after every DB non-reset edges.
REQ-016 A 2-bit scan index SHALL increment on each edge where CLK_FAST is high and wrap from 3 to 0.
REQ-017 selector SHALL equal the bitwise inverse of (1 << index), computed combinationally from the index.
REQ-018 dispDigit SHALL be the combinational active-low decode of the selected digit: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
REQ-019 Digit input values 10 to 15 SHALL decode to blank (7Fh).
REQ-020 A change on a digit input SHALL appear on dispDigit in the same cycle whenever that digit is selected.

Reset
REQ-021 While RESET is high, all divider counters SHALL clear to 0, all pulse outputs SHALL be 0, CLK_BLINK SHALL be 0, and the scan index SHALL be 0.
REQ-022 While RESET is high, selector SHALL be 1110b and dispDigit SHALL be decode(d0).
REQ-023 RESET asserted mid-period SHALL restart every phase, and the first pulses after release SHALL again follow REQ-013.

Configuration
REQ-024 When CLOCK_DISP_BLINK_EN is defined, the blink divider SHALL be built and CLK_BLINK SHALL behave per REQ-015.
REQ-025 When CLOCK_DISP_BLINK_EN is undefined, the blink divider SHALL be omitted and CLK_BLINK SHALL be tied to 0; all other behaviour is unchanged.

Structure
REQ-026 The package clock_disp_pkg SHALL hold the ten segment-pattern constants, the blank constant SEG_BLANK = 7Fh, and the 2-bit scan-index typedef.
REQ-027 The sub-module seg7_decode SHALL be a purely combinational BCD-to-segment decoder (4-bit input, 7-bit output) instantiated once.

Verification
Bench parameters for all scenarios: REF_HZ=1000, FAST_HZ=100, BLINK_HZ=2.
REQ-028 Divider scenario: hold RESET for 3 cycles, then release and run 2000 cycles -> CLK_2HZ is high for one cycle after edges 500, 1000, 1500 and 2000; CLK_1HZ is high for one cycle only after edges 1000 and 2000; no other highs on either output.
REQ-029 Refresh and scan scenario: run with d0..d3 = 1, 2, 3, 4 -> CLK_FAST is high after edges 10, 20, ...; selector steps 1110b, 1101b, 1011b, 0111b, 1110b; dispDigit shows 79h, 24h, 30h, 19h in step with selector.
REQ-030 Blank and decode scenario: set d0 = 12, then d0 = 8, with d0 selected -> dispDigit is 7Fh, then 00h in the same cycle as the change.
REQ-031 Blink scenario: with CLOCK_DISP_BLINK_EN defined, run 1000 cycles -> CLK_BLINK toggles after edges 250, 500, 750 and 1000. Rebuild without the macro -> CLK_BLINK stays 0 throughout.
REQ-032 Mid-run reset scenario: assert RESET at cycle 740 for 1 cycle -> selector is 1110b and all pulses are 0; the next CLK_2HZ pulse follows the 500th edge after release.
